// File: rtl/alu_issue.sv
// Decode-and-issue register stage for the SimpleRISC ALU.
// Decodes the opcode into one-hot ALU controls and owns the architectural flags.
module alu_issue #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  input  logic [31:0]           op1,
  input  logic [31:0]           op2,
  input  logic                  stall,
  input  logic                  flush,
  output logic [31:0]           A_ALU,
  output logic [31:0]           B_ALU,
  output logic [12:0]           aluSignals,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_wb,
  input  logic                  flagsE,
  input  logic                  flagsGT,
  output logic                  flags_e,
  output logic                  flags_gt
);

  logic [4:0]  opcode;
  logic        imm_sel;
  logic [1:0]  modifier;
  logic [15:0] imm16;
  logic [12:0] dec_sig;
  logic        dec_wb;
  logic [31:0] dec_b;
  logic        accept;
  logic        unused_inst_bits;

  assign opcode           = inst[31:27];
  assign imm_sel          = inst[26];
  assign modifier         = inst[17:16];
  assign imm16            = inst[15:0];
  assign unused_inst_bits = ^inst[21:18];

  assign in_ready = !ex_valid || !stall;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    dec_sig = '0;
    dec_wb  = 1'b1;
    case (opcode)
      5'b00000: dec_sig[0]  = 1'b1;
      5'b00001: dec_sig[1]  = 1'b1;
      5'b00010: dec_sig[3]  = 1'b1;
      5'b00011: dec_sig[4]  = 1'b1;
      5'b00100: dec_sig[5]  = 1'b1;
      5'b00101: begin
        dec_sig[2] = 1'b1;
        dec_wb     = 1'b0;
      end
      5'b00110: dec_sig[10] = 1'b1;
      5'b00111: dec_sig[9]  = 1'b1;
      5'b01000: dec_sig[11] = 1'b1;
      5'b01001: dec_sig[12] = 1'b1;
      5'b01010: dec_sig[6]  = 1'b1;
      5'b01011: dec_sig[7]  = 1'b1;
      5'b01100: dec_sig[8]  = 1'b1;
      5'b01110: dec_sig[0]  = 1'b1;
      5'b01111: begin
        dec_sig[0] = 1'b1;
        dec_wb     = 1'b0;
      end
      default: dec_wb = 1'b0;
    endcase
  end

  // Modifier 11 is treated like 00 (sign extension).
  always_comb begin
    dec_b = op2;
    if (imm_sel) begin
      case (modifier)
        2'b01:   dec_b = {16'h0000, imm16};
        2'b10:   dec_b = {imm16, 16'h0000};
        default: dec_b = {{16{imm16[15]}}, imm16};
      endcase
    end
  end

  // Operands and ex_rd are left untouched by bubbles; only the control bits clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_ALU      <= '0;
      B_ALU      <= '0;
      aluSignals <= '0;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_wb      <= 1'b0;
    end else if (accept) begin
      A_ALU      <= op1;
      B_ALU      <= dec_b;
      aluSignals <= dec_sig;
      ex_valid   <= 1'b1;
      ex_rd      <= inst[22 +: REG_ADDR_W];
      ex_wb      <= dec_wb;
    end else if (in_ready || flush) begin
      aluSignals <= '0;
      ex_valid   <= 1'b0;
      ex_wb      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_e  <= 1'b0;
      flags_gt <= 1'b0;
    end else if (ex_valid && aluSignals[2] && !stall && !flush) begin
      flags_e  <= flagsE;
      flags_gt <= flagsGT;
    end
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue pipeline register that drives the SimpleRISC ALU. It accepts one fetched instruction plus its register-file operands per cycle and decodes the opcode into the ALU's 13-bit one-hot `aluSignals`. It registers `A_ALU`, `B_ALU` and `aluSignals` toward the ALU with stall and flush control. It also owns the architectural flags register, capturing the ALU's combinational `flagsE`/`flagsGT` when a `cmp` retires from the execute slot.

## Interface
- `REG_ADDR_W`, 4, width of destination register index.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction and operands valid.
- `in_ready`  out  1  block accepts this cycle.
- `inst`  in  32  instruction: opcode [31:27], I [26], rd [25:22], modifier [17:16], imm16 [15:0].
- `op1`  in  32  rs1 value.
- `op2`  in  32  rs2 value.
- `stall`  in  1  downstream cannot take the execute-slot instruction.
- `flush`  in  1  kill execute-slot and incoming instruction.
- `A_ALU`  out  32  registered ALU operand A.
- `B_ALU`  out  32  registered ALU operand B.
- `aluSignals`  out  13  registered one-hot ALU control.
- `ex_valid`  out  1  execute slot holds a live instruction.
- `ex_rd`  out  REG_ADDR_W  destination register.
- `ex_wb`  out  1  instruction writes a register.
- `flagsE`, `flagsGT`  in  1 each  combinational flags from the ALU.
- `flags_e`, `flags_gt`  out  1 each  architectural flags to the branch unit.

## Operation
- aluSignals bit map: 0 add, 1 sub, 2 cmp, 3 mul, 4 div, 5 mod, 6 lsl, 7 lsr, 8 asr, 9 or, 10 and, 11 not, 12 mov.
- Opcode to bit mapping:
  - add 00000→0, sub 00001→1, mul 00010→3, div 00011→4, mod 00100→5, cmp 00101→2, and 00110→10, or 00111→9, not 01000→11, mov 01001→12, lsl 01010→6, lsr 01011→7, asr 01100→8.
  - ld 01110 and st 01111→0 (address add).
  - nop 01101, b/beq/bgt/call/ret (10000–10100) and undefined 10101–11111→all zero.
- At most one bit of `aluSignals` is ever set.
- `A_ALU` = `op1` for every opcode.
- `B_ALU` = `op2` when I=0.
- When I=1, `B_ALU` is the immediate, selected by modifier:
  - 00 and 11: sign-extend imm16.
  - 01: zero-extend imm16.
  - 10: imm16 << 16.
- `ex_wb` = 1 for add, sub, mul, div, mod, and, or, not, mov, lsl, lsr, asr and ld; 0 for all other opcodes.
- `ex_rd` = `inst[25:22]`.
- `in_ready` = !`ex_valid` | !`stall`, combinational.
- Accept condition: `in_valid` & `in_ready` & !`flush`. On accept, all decoded fields are loaded and `ex_valid` is set to 1.
- When `in_ready`=1 and there is no accept, a bubble is loaded: `ex_valid`=0, `aluSignals`=0, `ex_wb`=0. `A_ALU`/`B_ALU` hold their values.
- When `stall`=1 and `ex_valid`=1, every output register holds its value.
- `flush`=1 forces a bubble next cycle regardless of `stall` or `in_valid`.
- Flag capture:
  - Condition: `ex_valid` & `aluSignals[2]` & !`stall` & !`flush`.
  - Action: `flags_e` ← `flagsE`, `flags_gt` ← `flagsGT`.
  - Otherwise the flags hold. A flushed `cmp` never updates the flags.

## Timing
- Reset (async, `rst_n`=0): `A_ALU`, `B_ALU`, `aluSignals`, `ex_rd` = 0; `ex_valid`, `ex_wb`, `flags_e`, `flags_gt` = 0; `in_ready` = 1.
- Reset deassertion takes effect at the first rising edge after release. Reset mid-stall discards the held instruction.
- Latency is 1 cycle from accept edge to `aluSignals`/operands valid at the ALU.
- Flags become visible 1 cycle after the `cmp` leaves the execute slot.
- Throughput is 1 instruction/cycle when `stall`=0.
- Simultaneous cases:
  - `flush` and accept in the same cycle: flush wins and nothing is loaded.
  - `stall` and `flush` in the same cycle: flush wins.
  - `stall` while `ex_valid`=0: `in_ready`=1 and the slot fills.
- No combinational path from `inst` or operands to the outputs. The only combinational output is `in_ready`, which depends on `stall` and `ex_valid`.

## Test plan
- Reset, then `add` I=0 with op1=5, op2=7 → next cycle `aluSignals`=13'h0001, `A_ALU`=5, `B_ALU`=7, `ex_valid`=1, `ex_wb`=1.
- `mov` I=1 with imm16=16'hFFFE under each modifier → `aluSignals`=13'h1000 and `B_ALU` is:
  - modifier 00: 32'hFFFFFFFE.
  - modifier 01: 32'h0000FFFE.
  - modifier 10: 32'hFFFE0000.
- `cmp` with op1=9, op2=9, ALU returning flagsE=1/flagsGT=0, `stall`=0 → `flags_e`=1, `flags_gt`=0 one cycle after retire.
  - Repeat the `cmp` with `flush`=1 while it is in the execute slot → flags unchanged.
- `stall`=1 for 3 cycles with a `sub` in the execute slot and `in_valid`=1 → `in_ready`=0 and outputs frozen.
  - On release, the next instruction loads on the following edge.
- Stream `nop`, `beq`, opcode 11111, then `st` → `aluSignals` = 0, 0, 0, then 13'h0001; `ex_wb`=0 for all four.
- Assert `rst_n`=0 mid-stream during a stall → all outputs zero immediately (asynchronously), `in_ready`=1.
